// File: rtl/serial_ones_comp_adder.sv
// serial_ones_comp_adder: bit-serial ones'-complement adder/subtractor using one full-adder slice.
// Pass 1 adds the operands LSB first; an optional pass 2 folds the end-around carry back in.
`default_nettype none

module serial_ones_comp_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             eac,
  output logic             neg_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             eac_q, eac_d;
  logic             nz_q, nz_d;

  logic             slice_x, slice_y, slice_s, slice_c;
  logic             cnt_last;
  logic [WIDTH-1:0] sum_shift;

  // Shared full-adder slice: pass 2 re-reads the partial sum with a zero operand.
  always_comb begin
    slice_x   = (state_q == S_PASS1) ? a_q[0] : sum_q[0];
    slice_y   = (state_q == S_PASS1) ? b_q[0] : 1'b0;
    slice_s   = slice_x ^ slice_y ^ carry_q;
    slice_c   = (slice_x & slice_y) | (slice_x & carry_q) | (slice_y & carry_q);
    cnt_last  = (cnt_q == CNT_LAST);
    sum_shift = {slice_s, sum_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PASS1;
      S_PASS1: if (cnt_last) state_d = slice_c ? S_PASS2 : S_DONE;
      S_PASS2: if (cnt_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    result   = result_q;
    eac      = eac_q;
    neg_zero = nz_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    eac_d    = eac_q;
    nz_d     = nz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      S_PASS1: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_shift;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d = '0;
          // A set carry becomes the LSB carry-in of pass 2.
          if (!slice_c) begin
            result_d = sum_shift;
            eac_d    = 1'b0;
            nz_d     = &sum_shift;
          end
        end
      end
      S_PASS2: begin
        sum_d   = sum_shift;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_last) begin
          cnt_d    = '0;
          carry_d  = 1'b0;
          result_d = sum_shift;
          eac_d    = 1'b1;
          nz_d     = &sum_shift;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      eac_q    <= 1'b0;
      nz_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      eac_q    <= eac_d;
      nz_q     <= nz_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_ones_comp_adder.sv
// tb_serial_ones_comp_adder: scoreboard bench for the serial ones'-complement adder (WIDTH=4).
`default_nettype none

module tb_serial_ones_comp_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         eac;
  logic         neg_zero;

  typedef struct {
    logic [W-1:0] res;
    logic         eac;
    logic         nz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  serial_ones_comp_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .eac      (eac),
    .neg_zero (neg_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {eac, neg_zero, result}.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0]   t;
    logic [W-1:0] r;
    t = {1'b0, av} + {1'b0, (s ? ~bv : bv)};
    r = t[W-1:0] + {{(W-1){1'b0}}, t[W]};
    return {t[W], &r, r};
  endfunction

  // Monitor: ncyc counts falling edges, so the k-th cycle after an accepting edge sees ncyc = acc + k.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("result", int'(result), int'(e.res));
        check("eac", int'(eac), int'(e.eac));
        check("neg_zero", int'(neg_zero), int'(e.nz));
        check("latency", ncyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_idle(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (busy) begin
      n++;
      if (n > 60) begin
        check("idle_timeout", 0, 1);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic ee, input logic en);
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    sub   = s;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    q.push_back('{er, ee, en, (ee ? 2*W+1 : W+1), ncyc});
    #1 start = 1'b0;
  endtask

  initial begin
    bit           ok;
    int           acc1;
    int           n;
    logic [W+1:0] m;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_eac", int'(eac), 0);
    check("rst_neg_zero", int'(neg_zero), 0);
    rst_n = 1'b1;

    // Hand-computed vectors: sub, a, b -> result, eac, neg_zero.
    issue(1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    issue(1'b1, 4'b0011, 4'b0101, 4'b1101, 1'b0, 1'b0);
    issue(1'b1, 4'b0101, 4'b0101, 4'b1111, 1'b0, 1'b1);
    issue(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0);
    issue(1'b0, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0);
    issue(1'b0, 4'b1110, 4'b1101, 4'b1100, 1'b1, 1'b0);
    issue(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    issue(1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1);
    issue(1'b0, 4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b1);

    // start held high through a 9-cycle operation, then accepted again right after DONE.
    wait_idle(ok);
    sub   = 1'b1;
    a     = 4'b0101;
    b     = 4'b0011;
    start = 1'b1;
    @(posedge clk);
    acc1 = ncyc;
    q.push_back('{4'b0010, 1'b1, 1'b0, 2*W+1, acc1});
    for (int k = 1; k <= 2*W; k++) begin
      @(negedge clk);
      check("busy_cont", int'(busy), 1);
      sub = 1'($urandom);
      a   = 4'($urandom);
      b   = 4'($urandom);
    end
    @(negedge clk);
    check("busy_done_cycle", int'(busy), 1);
    sub = 1'b0;
    a   = 4'b0010;
    b   = 4'b0011;
    q.push_back('{4'b0101, 1'b0, 1'b0, W+1, acc1 + 2*W + 2});
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;

    // Reset during the second cycle of pass 2 aborts the operation.
    issue(1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0);
    repeat (W + 2) @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_eac", int'(eac), 0);
    check("abort_neg_zero", int'(neg_zero), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("post_abort_idle", int'(busy), 0);

    // Exhaustive sweep against the arithmetic reference.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          m = model(1'(s), 4'(x), 4'(y));
          issue(1'(s), 4'(x), 4'(y), m[W-1:0], m[W+1], m[W]);
        end
      end
    end

    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", int'(q.size()), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_ones_comp_adder.md
SERIAL_ONES_COMP_ADDER -- requirements
Module: serial_ones_comp_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0: a+b, 1: a-b (b ones'-complemented); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A, ones'-complement; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, ones'-complement; sampled with start.
REQ-008 SHALL have port busy  output  1  high in PASS1, PASS2, DONE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  WIDTH  registered ones'-complement sum/difference.
REQ-011 SHALL have port eac  output  1  end-around carry produced by pass 1.
REQ-012 SHALL have port neg_zero  output  1  result is all ones (negative zero).

Function
REQ-013 SHALL implement FSM states IDLE, PASS1, PASS2, DONE.
REQ-014 In IDLE with start=1, SHALL latch a, b^{WIDTH{sub}} into operand shift registers, clear the bit counter and serial carry to 0, and enter PASS1.
REQ-015 PASS1 SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles, using a single full-adder slice (sum = x^y^c, carry = majority).
REQ-016 After the WIDTH-th PASS1 cycle, SHALL store the final carry as the end-around carry; enter PASS2 if it is 1, else DONE.
REQ-017 PASS2 SHALL add the end-around carry to the partial sum bit-serially (carry-in 1 at LSB, operand 0) for exactly WIDTH cycles, then enter DONE; carry out of PASS2 is discarded (cannot be 1 for legal arithmetic).
REQ-018 DONE SHALL last exactly one cycle, assert done=1, then return to IDLE.
REQ-019 result, eac and neg_zero SHALL update only on the edge entering DONE, and hold until the next entry to DONE or reset.
REQ-020 Latency: done SHALL be high WIDTH+1 cycles after the accepting edge when eac=0, 2*WIDTH+1 cycles when eac=1.
REQ-021 start while busy=1 SHALL be ignored with no effect on the operation in progress; start during the DONE cycle is also ignored.
REQ-022 Back-to-back: start held high continuously SHALL be accepted in the first IDLE cycle after DONE.
REQ-023 neg_zero SHALL equal AND-reduction of the new result; positive zero (all zeros) SHALL NOT set it.
REQ-024 The block SHALL NOT normalise negative zero to positive zero.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and busy=0, done=0, result=0, eac=0, neg_zero=0, internal counter/carry/shift registers=0.
REQ-026 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow deassertion.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-028 WIDTH=4, sub=1, a=0101, b=0011 -> eac=1, result=0010, neg_zero=0, done 9 cycles after accept.
REQ-029 WIDTH=4, sub=1, a=0011, b=0101 -> eac=0, result=1101 (-2), done 5 cycles after accept.
REQ-030 WIDTH=4, sub=1, a=b=0101 -> result=1111, neg_zero=1, eac=0; sub=0, a=1111, b=0001 -> result=0001, eac=1.
REQ-031 Start pulsed every cycle during a 9-cycle operation -> exactly one done, result of first request only, busy continuous.
REQ-032 rst_n pulsed low at PASS2 cycle 2 -> all outputs 0 immediately, no done within 20 cycles of idle start=0.
REQ-033 Exhaustive WIDTH=4 sweep, all a, b, sub -> result matches ones'-complement reference model, latency per REQ-020.
